// File: rtl/alu_result_checker.sv
// Checks a 4-bit ALU stage against a golden model: counts vectors and mismatches,
// captures the first failing vector and raises an alarm. Optional mismatch log: CHECKER_LOG_EN.
module alu_result_checker #(
  parameter int ALARM_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic [1:0]  in_op,
  input  logic [3:0]  in_res,
  input  logic        in_cout,
  input  logic        clr,
  output logic        err_pulse,
  output logic        alarm,
  output logic [1:0]  state,
  output logic [7:0]  err_count,
  output logic [7:0]  vec_count,
  output logic [14:0] first_err,
  input  logic        log_pop,
  output logic        log_valid,
  output logic [14:0] log_data,
  output logic        log_ovf
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, ALARM = 2'b10} state_t;

  localparam logic [7:0] THRESH = 8'(ALARM_THRESH);

  state_t      state_reg, state_next;
  logic [4:0]  golden;
  logic        mismatch;
  logic [7:0]  err_upd;
  logic        err_pulse_reg;
  logic [7:0]  err_count_reg, vec_count_reg;
  logic [14:0] first_err_reg;
  logic [14:0] entry;

  always_comb begin
    golden = 5'd0;
    case (in_op)
      2'b00:   golden = {1'b0, in_a} + {1'b0, in_b};
      2'b01:   golden = {1'b0, in_a} - {1'b0, in_b};
      2'b10:   golden = {1'b0, in_a & in_b};
      default: golden = {1'b0, in_a | in_b};
    endcase
  end

  assign mismatch = in_valid && ({in_cout, in_res} != golden);
  assign err_upd  = (mismatch && err_count_reg != 8'hFF) ? err_count_reg + 8'd1 : err_count_reg;
  assign entry    = {in_a, in_b, in_op, in_res, in_cout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_reg <= 1'b0;
      err_count_reg <= 8'd0;
      vec_count_reg <= 8'd0;
      first_err_reg <= 15'd0;
    end else if (clr) begin
      err_pulse_reg <= 1'b0;
      err_count_reg <= 8'd0;
      vec_count_reg <= 8'd0;
      first_err_reg <= 15'd0;
    end else if (in_valid) begin
      err_pulse_reg <= mismatch;
      err_count_reg <= err_upd;
      vec_count_reg <= vec_count_reg + 8'd1;
      if (mismatch && err_count_reg == 8'd0)
        first_err_reg <= entry;
    end else begin
      err_pulse_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // The threshold is judged on the count including this edge's vector.
  always_comb begin
    state_next = state_reg;
    if (clr)
      state_next = IDLE;
    else if (in_valid && state_reg != ALARM)
      state_next = (err_upd >= THRESH) ? ALARM : RUN;
  end

  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;
  assign vec_count = vec_count_reg;
  assign first_err = first_err_reg;
  assign state     = state_reg;
  assign alarm     = (state_reg == ALARM);

`ifdef CHECKER_LOG_EN
  logic [14:0] log_mem [4];
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]  log_cnt_reg;
  logic        log_ovf_reg;
  logic        push_req, push, pop, full;

  assign full     = (log_cnt_reg == 3'd4);
  assign pop      = log_pop && (log_cnt_reg != 3'd0) && !clr;
  assign push_req = mismatch && !clr;
  // A full log still accepts a push when the head leaves at the same edge.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push)
      log_mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= 2'd0;
      rd_ptr_reg  <= 2'd0;
      log_cnt_reg <= 3'd0;
      log_ovf_reg <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg  <= 2'd0;
      rd_ptr_reg  <= 2'd0;
      log_cnt_reg <= 3'd0;
      log_ovf_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      if (push && !pop)      log_cnt_reg <= log_cnt_reg + 3'd1;
      else if (pop && !push) log_cnt_reg <= log_cnt_reg - 3'd1;
      if (push_req && !push) log_ovf_reg <= 1'b1;
    end
  end

  assign log_valid = (log_cnt_reg != 3'd0);
  assign log_data  = log_valid ? log_mem[rd_ptr_reg] : 15'd0;
  assign log_ovf   = log_ovf_reg;
`else
  logic unused_log_pop;
  assign unused_log_pop = log_pop;
  assign log_valid = 1'b0;
  assign log_data  = 15'd0;
  assign log_ovf   = 1'b0;
`endif

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 SHALL have parameter ALARM_THRESH, default 1, error count (1..255) at which the alarm state is entered.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have in_valid  input  1  vector strobe, one vector sampled per rising edge while high.
REQ-005 SHALL have in_a, in_b  input  4 each  ALU operands as presented to the ALU stage.
REQ-006 SHALL have in_op  input  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 SHALL have in_res  input  4, in_cout  input  1  ALU result and carry under check.
REQ-008 SHALL have clr  input  1  synchronous clear of counters, capture and alarm.
REQ-009 SHALL have err_pulse  output  1  one-cycle mismatch flag.
REQ-010 SHALL have alarm  output  1  high while state is ALARM.
REQ-011 SHALL have state  output  2  FSM state: 00 IDLE, 01 RUN, 10 ALARM.
REQ-012 SHALL have err_count  output  8, vec_count  output  8  mismatch and vector counters.
REQ-013 SHALL have first_err  output  15  first mismatching vector {a,b,op,res,cout}.
REQ-014 SHALL have log_pop  input  1, log_valid  output  1, log_data  output  15, log_ovf  output  1  mismatch log port.

Function
REQ-015 Golden model: ADD {cout,res}=a+b in 5 bits; SUB {cout,res}=a-b modulo 32, so cout=1 exactly when a<b; AND res=a&b, cout=0; OR res=a|b, cout=0.
REQ-016 Mismatch means in_valid=1 and {in_cout,in_res} differs from the golden {cout,res} in any bit.
REQ-017 Latency: vector sampled at edge N; err_pulse, counters, first_err and state updated and visible after edge N, for exactly one cycle in err_pulse's case.
REQ-018 vec_count increments on every sampled vector and wraps 255->0.
REQ-019 err_count increments on each mismatch and saturates at 255.
REQ-020 first_err loads only on a mismatch while err_count=0, and holds until reset or clr.
REQ-021 FSM: IDLE->RUN on the first sampled vector; RUN->ALARM when the updated err_count >= ALARM_THRESH; ALARM stays until clr; IDLE can go directly to ALARM if the first vector mismatches and ALARM_THRESH=1.
REQ-022 clr=1 at an edge: err_count, vec_count, first_err, err_pulse and log_ovf go to 0, state goes to IDLE, and the log is emptied; a vector with in_valid=1 at that same edge is discarded.
REQ-023 Inputs are undefined-tolerant when in_valid=0: no counter, state or log change.

Reset
REQ-024 rst_n low SHALL immediately force err_pulse=0, alarm=0, state=IDLE, err_count=0, vec_count=0, first_err=0, log_valid=0, log_data=0, log_ovf=0.
REQ-025 Reset assertion mid-stream SHALL discard any sampled vector; the first edge after deassertion behaves as from IDLE.

Configuration
REQ-026 Macro CHECKER_LOG_EN defined: a 4-entry FIFO pushes {a,b,op,res,cout} on each mismatch; log_valid=not empty; log_data=head entry; log_pop with log_valid=1 removes the head at the edge.
REQ-027 With CHECKER_LOG_EN: a push when full and no pop drops the vector and sets log_ovf (sticky until clr or reset); a push with a pop when full is accepted; a pop when empty is ignored.
REQ-028 Without CHECKER_LOG_EN: the ports remain; log_valid, log_data and log_ovf are tied to 0, log_pop is ignored, and no FIFO storage is built.

Verification
REQ-029 Reset, then in_valid with a=3, b=4, op=00, res=7, cout=0 -> err_pulse=0, vec_count=1, state=RUN.
REQ-030 a=2, b=5, op=01, res=D, cout=1 -> no mismatch; then the same vector with cout=0 -> err_pulse=1 for one cycle, err_count=1, first_err={2,5,01,D,0}, alarm=1 (ALARM_THRESH=1).
REQ-031 ALARM_THRESH=3: three mismatches (a=F, b=F, op=00, res=F, cout=0) with good vectors interleaved -> alarm is first high after the third mismatch; first_err keeps the first vector.
REQ-032 300 consecutive mismatches -> err_count=255 (saturated) and vec_count=44 (wrapped); clr at the same edge as a valid vector -> all zero, state=IDLE, vec_count stays 0.
REQ-033 CHECKER_LOG_EN: 5 mismatches with no pop -> log_ovf=1 and the 4 oldest entries pop in order; push and pop in the same cycle when full -> 4 entries kept, log_ovf unchanged.
REQ-034 rst_n pulsed low mid-stream with alarm=1 -> all outputs 0 asynchronously, before the next clk edge.
